spi_master_fifo: RTL and testbench

SPI_MASTER_FIFO -- requirements
Module: spi_master_fifo

---
 rtl/spi_pkg.sv | 43 ++++
 rtl/spi_master_fifo_fifo.sv | 60 ++++++
 rtl/spi_master_fifo.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared register map, CON/STATUS bit positions and engine
//                state encoding for the SPI master with FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Register offsets within the decoded 3-bit address field
    localparam logic [2:0] c_addr_con    = 3'd0;
    localparam logic [2:0] c_addr_clkdiv = 3'd1;
    localparam logic [2:0] c_addr_txdata = 3'd2;
    localparam logic [2:0] c_addr_rxdata = 3'd3;
    localparam logic [2:0] c_addr_status = 3'd4;

    // CON bit positions
    localparam int c_con_busy    = 0;
    localparam int c_con_cpol    = 1;
    localparam int c_con_cpha    = 2;
    localparam int c_con_cont    = 3;
    localparam int c_con_en      = 4;
    localparam int c_con_sel_lsb = 5;
    localparam int c_con_sel_msb = 7;

    // STATUS bit positions
    localparam int c_st_tx_empty = 0;
    localparam int c_st_tx_full  = 1;
    localparam int c_st_rx_empty = 2;
    localparam int c_st_rx_full  = 3;
    localparam int c_st_tx_ovf   = 4;
    localparam int c_st_rx_ovf   = 5;

    // Shift engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_fifo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_fifo
//  Description : Synchronous show-ahead FIFO with full/empty flags. A push
//                and a pop in the same cycle leave the occupancy unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_fifo
//  Description : CPU-programmable SPI master with TX/RX byte FIFOs, selectable
//                CPOL/CPHA, continuous-select mode and up to 8 slave selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int SLAVES     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_LSB   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [SLAVES-1:0] ss_n
);

    // CPU-visible registers (CON bit 0 is the read-only busy flag)
    logic [7:1]        r_con;
    logic [7:0]        r_clkdiv;
    logic              r_tx_ovf;
    logic              r_rx_ovf;
    logic [7:0]        r_dout;

    // Engine state
    spi_state_t        r_state;
    logic [7:0]        r_cnt;
    logic [7:0]        r_div;
    logic [3:0]        r_edge;
    logic              r_cpha;
    logic [7:0]        r_tx;
    logic [7:0]        r_rx;
    logic              r_sclk;
    logic              r_mosi;
    logic [SLAVES-1:0] r_ss_n;

    // FIFO interface
    logic [7:0]        w_tx_rdata;
    logic [7:0]        w_rx_rdata;
    logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

    logic [2:0]        w_reg_sel;
    logic              w_cpu_rd;
    logic              w_busy;
    logic              w_can_start;
    logic              w_tick;
    logic              w_last_edge;
    logic              w_odd_edge;
    logic              w_shift_now;
    logic              w_sample_now;
    logic [7:0]        w_rx_next;
    logic [7:0]        w_rx_byte;
    logic [7:0]        w_rd_data;
    logic [SLAVES-1:0] w_ss_sel;
    logic              w_unused_addr;

    assign w_reg_sel     = addr[ADDR_LSB+2:ADDR_LSB];
    assign w_unused_addr = ^addr;
    assign w_cpu_rd      = rd_en & ~wr_en;
    assign w_busy        = (r_state != ST_IDLE);

    assign w_tx_push = wr_en & (w_reg_sel == c_addr_txdata) & ~w_tx_full;
    assign w_rx_pop  = w_cpu_rd & (w_reg_sel == c_addr_rxdata) & ~w_rx_empty;

    // Frame timing: one sclk edge per CLKDIV+1 cycles; r_edge counts edges done
    assign w_tick       = (r_cnt == r_div);
    assign w_last_edge  = (r_state == ST_SHIFT) & w_tick & (r_edge == 4'd15);
    assign w_odd_edge   = ~r_edge[0];
    assign w_shift_now  = r_cpha ? w_odd_edge : ~w_odd_edge;
    assign w_sample_now = r_cpha ? ~w_odd_edge : w_odd_edge;
    assign w_rx_next    = {r_rx[6:0], miso};
    // With cpha=1 the eighth sample lands on the final edge itself
    assign w_rx_byte    = r_cpha ? w_rx_next : r_rx;

    // A new frame starts from IDLE, or back-to-back at the end of SHIFT
    assign w_can_start = r_con[c_con_en] & ~w_tx_empty;
    assign w_tx_pop    = ((r_state == ST_IDLE) & w_can_start) |
                         (w_last_edge & r_con[c_con_cont] & w_can_start);
    assign w_rx_push   = w_last_edge & ~w_rx_full;

    // Decode the slave index into active-low selects; out-of-range selects none
    always_comb begin
        w_ss_sel = '1;
        for (int i = 0; i < SLAVES; i++) begin
            if (r_con[c_con_sel_msb:c_con_sel_lsb] == 3'(i)) w_ss_sel[i] = 1'b0;
        end
    end

    // CPU read multiplexer; unmapped addresses read as zero
    always_comb begin
        w_rd_data = 8'h00;
        case (w_reg_sel)
            c_addr_con:    w_rd_data = {r_con, w_busy};
            c_addr_clkdiv: w_rd_data = r_clkdiv;
            c_addr_rxdata: w_rd_data = w_rx_empty ? 8'h00 : w_rx_rdata;
            c_addr_status: begin
                w_rd_data[c_st_tx_empty] = w_tx_empty;
                w_rd_data[c_st_tx_full]  = w_tx_full;
                w_rd_data[c_st_rx_empty] = w_rx_empty;
                w_rd_data[c_st_rx_full]  = w_rx_full;
                w_rd_data[c_st_tx_ovf]   = r_tx_ovf;
                w_rd_data[c_st_rx_ovf]   = r_rx_ovf;
            end
            default: w_rd_data = 8'h00;
        endcase
    end

    // CPU register writes, sticky overflow flags and registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_con    <= '0;
            r_clkdiv <= '0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_dout   <= 8'h00;
        end else begin
            if (wr_en) begin
                case (w_reg_sel)
                    c_addr_con:    r_con    <= din[7:1];
                    c_addr_clkdiv: r_clkdiv <= din;
                    c_addr_txdata: if (w_tx_full) r_tx_ovf <= 1'b1;
                    c_addr_status: begin
                        if (din[c_st_tx_ovf]) r_tx_ovf <= 1'b0;
                        if (din[c_st_rx_ovf]) r_rx_ovf <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // A fresh overflow wins over a simultaneous clear
            if (w_last_edge & w_rx_full) r_rx_ovf <= 1'b1;
            if (w_cpu_rd) r_dout <= w_rd_data;
        end
    end

    // Shift engine: IDLE -> SETUP -> SHIFT -> (SETUP | GAP) -> IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_edge  <= '0;
            r_cpha  <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_ss_n  <= '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sclk <= r_con[c_con_cpol];
                    if (w_tx_pop) r_state <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + 1'b1;
                        if (w_shift_now) begin
                            r_mosi <= r_cpha ? r_tx[7] : r_tx[6];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                        if (w_sample_now) r_rx <= w_rx_next;
                        if (r_edge == 4'd15) begin
                            if (w_tx_pop) begin
                                r_state <= ST_SETUP;
                            end else begin
                                r_state <= ST_GAP;
                                r_ss_n  <= '1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Frame start: mode, divider and slave are sampled only here
            if (w_tx_pop) begin
                r_cnt  <= '0;
                r_div  <= r_clkdiv;
                r_cpha <= r_con[c_con_cpha];
                r_tx   <= w_tx_rdata;
                r_ss_n <= w_ss_sel;
                r_sclk <= r_con[c_con_cpol];
                // cpha=0 presents the first bit before the first edge
                if (!r_con[c_con_cpha]) r_mosi <= w_tx_rdata[7];
            end
        end
    end

    assign dout = r_dout;
    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign ss_n = r_ss_n;

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_tx_push),
        .pop     (w_tx_pop),
        .wdata   (din),
        .rdata   (w_tx_rdata),
        .full    (w_tx_full),
        .empty   (w_tx_empty)
    );

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_rx_push),
        .pop     (w_rx_pop),
        .wdata   (w_rx_byte),
        .rdata   (w_rx_rdata),
        .full    (w_rx_full),
        .empty   (w_rx_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_master_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_fifo
//  Description : Directed self-checking bench for spi_master_fifo with MISO
//                looped back to MOSI.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_fifo;

    localparam int SLAVES = 1;
    localparam logic [7:0] A_CON = 8'd0, A_DIV = 8'd1, A_TX = 8'd2,
                           A_RX = 8'd3, A_ST = 8'd4, A_NONE = 8'd5, A_LAST = 8'd7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        addr, din, dout;
    logic              wr_en, rd_en;
    logic              sclk, mosi, miso;
    logic [SLAVES-1:0] ss_n;

    int n_cmp  = 0;
    int n_fail = 0;

    assign miso = mosi;

    always #5 clk = ~clk;

    spi_master_fifo #(.SLAVES(SLAVES), .FIFO_DEPTH(4), .ADDR_LSB(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n)
    );

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; din = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = dout;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if (ss_n !== {SLAVES{1'b1}}) begin n_fail++; $display("FAIL reset_ss_n: got %b want all ones", ss_n); end
        n_cmp++; if ({sclk, mosi} !== 2'b00) begin n_fail++; $display("FAIL reset_sclk_mosi: got %b want 00", {sclk, mosi}); end
        reset_n = 1'b1;
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h05) begin n_fail++; $display("FAIL reset_status: got %h want 05", v); end
        rd(A_CON, v);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_con: got %h want 00", v); end
    endtask

    task automatic test_regs();
        logic [7:0] v;
        wr(A_DIV, 8'h5A);
        rd(A_DIV, v);
        n_cmp++; if (v !== 8'h5A) begin n_fail++; $display("FAIL clkdiv_rb: got %h want 5a", v); end
        wr(A_NONE, 8'hFF);
        rd(A_NONE, v);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL addr5_read: got %h want 00", v); end
        rd(A_LAST, v);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL addr7_read: got %h want 00", v); end
        // Simultaneous write and read: write wins, dout holds
        @(negedge clk);
        addr = A_DIV; din = 8'h33; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL wr_priority_dout: got %h want 00", dout); end
        rd(A_DIV, v);
        n_cmp++; if (v !== 8'h33) begin n_fail++; $display("FAIL wr_priority_div: got %h want 33", v); end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        int low = 0, rises = 0;
        logic prev;
        wr(A_DIV, 8'h01);
        wr(A_TX, 8'hA5);
        wr(A_CON, 8'h10);
        prev = sclk;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ss_n[0] == 1'b0) low++;
            if (!prev && sclk) rises++;
            prev = sclk;
        end
        // SETUP 2 cycles + SHIFT 32 cycles with ss_n low
        n_cmp++; if (low != 34) begin n_fail++; $display("FAIL basic_ss_low_cycles: got %0d want 34", low); end
        n_cmp++; if (rises != 8) begin n_fail++; $display("FAIL basic_sclk_rises: got %0d want 8", rises); end
        rd(A_CON, v);
        n_cmp++; if (v !== 8'h10) begin n_fail++; $display("FAIL basic_busy_clear: got %h want 10", v); end
        rd(A_RX, v);
        n_cmp++; if (v !== 8'hA5) begin n_fail++; $display("FAIL basic_rx: got %h want a5", v); end
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h05) begin n_fail++; $display("FAIL basic_status: got %h want 05", v); end
    endtask

    task automatic test_mode();
        logic [7:0] v;
        int viol = 0, changes = 0;
        logic p_sclk, p_mosi, p_ss;
        wr(A_CON, 8'h16);
        repeat (3) @(negedge clk);
        n_cmp++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL mode_idle_high: got %b want 1", sclk); end
        wr(A_TX, 8'h3C);
        p_sclk = sclk; p_mosi = mosi; p_ss = ss_n[0];
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!p_ss && !ss_n[0] && (mosi != p_mosi)) begin
                changes++;
                if (!(p_sclk && !sclk)) viol++;
            end
            p_sclk = sclk; p_mosi = mosi; p_ss = ss_n[0];
        end
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL mode_mosi_on_fall: got %0d bad changes want 0", viol); end
        n_cmp++; if (changes != 2) begin n_fail++; $display("FAIL mode_mosi_changes: got %0d want 2", changes); end
        n_cmp++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL mode_end_high: got %b want 1", sclk); end
        rd(A_RX, v);
        n_cmp++; if (v !== 8'h3C) begin n_fail++; $display("FAIL mode_rx: got %h want 3c", v); end
    endtask

    task automatic test_cont();
        logic [7:0] v;
        logic [7:0] exp_b [3];
        int low = 0, ends = 0;
        logic p_ss;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        wr(A_CON, 8'h00);
        wr(A_DIV, 8'h00);
        for (int i = 0; i < 3; i++) wr(A_TX, exp_b[i]);
        wr(A_CON, 8'h18);
        p_ss = ss_n[0];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ss_n[0] == 1'b0) low++;
            if (!p_ss && ss_n[0]) ends++;
            p_ss = ss_n[0];
        end
        // Three frames of SETUP 1 + SHIFT 16 with no deselect between them
        n_cmp++; if (low != 51) begin n_fail++; $display("FAIL cont_ss_low_cycles: got %0d want 51", low); end
        n_cmp++; if (ends != 1) begin n_fail++; $display("FAIL cont_ss_deselects: got %0d want 1", ends); end
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL cont_status: got %h want 01", v); end
        for (int i = 0; i < 3; i++) begin
            rd(A_RX, v);
            n_cmp++; if (v !== exp_b[i]) begin n_fail++; $display("FAIL cont_rx%0d: got %h want %h", i, v, exp_b[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        wr(A_CON, 8'h00);
        wr(A_DIV, 8'h00);
        for (int i = 1; i <= 5; i++) wr(A_TX, 8'(i));
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h16) begin n_fail++; $display("FAIL ovf_tx_status: got %h want 16", v); end
        wr(A_ST, 8'h10);
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h06) begin n_fail++; $display("FAIL ovf_tx_clear: got %h want 06", v); end
        wr(A_CON, 8'h10);
        repeat (120) @(negedge clk);
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h09) begin n_fail++; $display("FAIL ovf_rx_full: got %h want 09", v); end
        wr(A_TX, 8'h06);
        repeat (40) @(negedge clk);
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h29) begin n_fail++; $display("FAIL ovf_rx_status: got %h want 29", v); end
        for (int i = 1; i <= 4; i++) begin
            rd(A_RX, v);
            n_cmp++; if (v !== 8'(i)) begin n_fail++; $display("FAIL ovf_rx%0d: got %h want %h", i, v, 8'(i)); end
        end
        rd(A_RX, v);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_5th_lost: got %h want 00", v); end
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h25) begin n_fail++; $display("FAIL ovf_rx_flag: got %h want 25", v); end
        wr(A_ST, 8'h20);
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h05) begin n_fail++; $display("FAIL ovf_rx_clear: got %h want 05", v); end
    endtask

    task automatic test_rx_empty();
        logic [7:0] v;
        rd(A_RX, v);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL rx_empty_read: got %h want 00", v); end
        rd(A_ST, v);
        n_cmp++; if (v[2] !== 1'b1) begin n_fail++; $display("FAIL rx_empty_flag: got %b want 1", v[2]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        wr(A_CON, 8'h00);
        wr(A_DIV, 8'h03);
        wr(A_TX, 8'hF0);
        wr(A_TX, 8'h0F);
        wr(A_CON, 8'h12);
        repeat (8) @(negedge clk);
        rd(A_CON, v);
        n_cmp++; if (v !== 8'h13) begin n_fail++; $display("FAIL mid_busy: got %h want 13", v); end
        repeat (10) @(negedge clk);
        n_cmp++; if (ss_n !== {SLAVES{1'b0}}) begin n_fail++; $display("FAIL mid_selected: got %b want 0", ss_n); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (ss_n !== {SLAVES{1'b1}}) begin n_fail++; $display("FAIL mid_rst_ss_n: got %b want all ones", ss_n); end
        n_cmp++; if ({sclk, mosi} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_sclk_mosi: got %b want 00", {sclk, mosi}); end
        n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL mid_rst_dout: got %h want 00", dout); end
        @(negedge clk);
        reset_n = 1'b1;
        rd(A_CON, v);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_con_idle: got %h want 00", v); end
        rd(A_DIV, v);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_clkdiv: got %h want 00", v); end
        rd(A_ST, v);
        n_cmp++; if (v !== 8'h05) begin n_fail++; $display("FAIL mid_fifos_empty: got %h want 05", v); end
        repeat (20) @(negedge clk);
        n_cmp++; if (ss_n !== {SLAVES{1'b1}}) begin n_fail++; $display("FAIL mid_no_restart: got %b want all ones", ss_n); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic();
        test_mode();
        test_cont();
        test_overflow();
        test_rx_empty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
